reg_to_obi_bridge: RTL and testbench
====================================

Name: reg_to_obi_bridge

Overview:
Register-bus responder that replays each accepted reg-bus transfer as one OBI initiator transaction. It is the opposite direction of the OBI-to-regbus path that feeds the peripheral subsystem. It lets reg-bus-only masters (debug/config engines, test harnesses) reach the OBI crossbar. Strictly one transaction outstanding; all OBI and reg-bus response outputs are registered.

Parameters:
- TIMEOUT_CYCLES, 1024: RESP-state cycles without obi_rvalid_i before an error response is forced. Used only with the optional feature.
- ERR_RDATA, 32'hBADCAB1E: rdata returned on a timeout error.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- reg_valid_i  in  1  reg-bus request valid; held with stable fields until reg_ready_o
- reg_write_i  in  1  1 = write, 0 = read
- reg_addr_i  in  32  byte address
- reg_wdata_i  in  32  write data
- reg_wstrb_i  in  4  byte strobes (writes only)
- reg_ready_o  out  1  one-cycle completion pulse
- reg_rdata_o  out  32  read data, valid when reg_ready_o
- reg_error_o  out  1  error flag, valid when reg_ready_o
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  word-aligned address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  4  byte enables
- obi_wdata_o  out  32  write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  32  OBI response data

Behaviour:
- Reset (asynchronous) values: all outputs 0; FSM in IDLE; timeout counter 0; drop_pending 0.
- States: IDLE, REQ, RESP, DONE, plus DRAIN when the optional feature is compiled in.
- IDLE:
  - On reg_valid_i, latch the request:
    - obi_addr_o = {reg_addr_i[31:2], 2'b00}
    - obi_we_o = reg_write_i
    - obi_be_o = reg_write_i ? reg_wstrb_i : 4'hF
    - obi_wdata_o = reg_wdata_i
  - Set obi_req_o = 1 and go to REQ.
  - Exception: a write with reg_wstrb_i == 0 issues no OBI traffic. It goes straight to DONE with error = 0 and rdata = 0.
- REQ:
  - obi_req_o and all OBI address-phase outputs stay stable until obi_gnt_i. OBI rule: no withdrawal and no timeout in this state.
  - On obi_gnt_i: clear obi_req_o and go to RESP.
  - obi_rvalid_i is never expected in the grant cycle. If it arrives there, it is ignored.
- RESP:
  - On obi_rvalid_i: register reg_rdata_o = obi_we_o ? 0 : obi_rdata_i and reg_error_o = 0, then go to DONE.
- DONE:
  - reg_ready_o = 1 for exactly this cycle, then go to IDLE.
  - reg_valid_i seen in this cycle belongs to the finishing transfer and is not re-accepted.
  - reg_rdata_o and reg_error_o hold their values until the next completion.
- Latency: with grant in the first REQ cycle and rvalid the next cycle, reg_valid_i at cycle 0 gives obi_req_o at 1, rvalid at 2, reg_ready_o at 3. Minimum is 4 cycles per transfer; back-to-back transfers start one cycle after ready.
- Sub-word reads return the full word; the master selects the byte lanes it needs.
- Reset mid-transaction: the FSM aborts immediately and obi_req_o drops. This is accepted; the system resets the OBI fabric together with the bridge.

Optional Feature:
- Macro: REG_TO_OBI_BRIDGE_TIMEOUT_EN.
- With the macro:
  - Counter width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to RESP and increments every RESP cycle without obi_rvalid_i.
  - When the count reaches TIMEOUT_CYCLES-1 without rvalid: go to DONE with reg_error_o = 1, reg_rdata_o = ERR_RDATA, and set drop_pending.
  - IDLE with drop_pending still accepts a request but moves to DRAIN, not REQ, and keeps obi_req_o low.
  - DRAIN waits for obi_rvalid_i, which clears drop_pending, then goes to REQ.
  - A late rvalid arriving in IDLE clears drop_pending and is otherwise discarded.
  - rvalid in the same cycle as expiry counts as a normal response; no error.
- Without the macro: no counter, no DRAIN state, reg_error_o is tied to 0, and RESP waits indefinitely.

Test Plan:
- Read with addr 0x2000_0406, gnt immediate, rvalid next cycle with rdata 0xCAFEF00D -> obi_addr_o 0x2000_0404, obi_be_o 0xF, obi_we_o 0; reg_ready_o at cycle 3 with rdata 0xCAFEF00D, error 0.
- Write with addr 0x10, wdata 0x1234_5678, wstrb 0x6, gnt held off 5 cycles -> obi_req_o and address-phase outputs stable for 6 cycles, be 0x6; after rvalid, reg_ready_o pulses one cycle with rdata 0.
- Write with wstrb 0 -> obi_req_o never asserts; reg_ready_o at cycle 1, error 0.
- Two back-to-back reads, valid held continuously -> two distinct OBI transactions and exactly two one-cycle ready pulses, rdata matching each response in order.
- TIMEOUT_EN, TIMEOUT_CYCLES = 8, rvalid withheld, then a late rvalid during a new request -> error = 1 with rdata 0xBADCAB1E after 8 RESP cycles; the new request sits in DRAIN until the late rvalid, then issues obi_req_o and returns its own data.
- Assert rst_ni low while in REQ -> obi_req_o and reg_ready_o go to 0 without waiting for a clock edge; FSM restarts in IDLE and the next read completes normally.

Source files
------------

// File: rtl/reg_to_obi_bridge.sv
// reg_to_obi_bridge
//   Register-bus responder that replays each accepted reg-bus transfer as a
//   single OBI initiator transaction. Only one transaction is in flight at a
//   time, and every OBI and reg-bus response output comes from a register.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   reg_valid_i/reg_write_i  reg-bus request (fields held stable until ready)
//   reg_addr_i/wdata/wstrb   reg-bus request address, write data, strobes
//   reg_ready_o              one-cycle completion pulse
//   reg_rdata_o/reg_error_o  response data and error flag, valid with ready
//   obi_req_o/obi_gnt_i      OBI address-phase handshake
//   obi_addr_o/we/be/wdata   OBI address-phase fields (word-aligned address)
//   obi_rvalid_i/obi_rdata_i OBI response phase
//
// Optional feature (macro REG_TO_OBI_BRIDGE_TIMEOUT_EN):
//   A response timeout of TIMEOUT_CYCLES RESP cycles forces an error
//   completion with ERR_RDATA. The late response that is still owed by the
//   fabric is then absorbed in IDLE or in a DRAIN state before the next
//   request goes out. Without the macro RESP waits indefinitely and
//   reg_error_o is constant 0.
module reg_to_obi_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hBADCAB1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        reg_valid_i,
  input  logic        reg_write_i,
  input  logic [31:0] reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic [3:0]  reg_wstrb_i,
  output logic        reg_ready_o,
  output logic [31:0] reg_rdata_o,
  output logic        reg_error_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] RESP  = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0] state;

`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  // Set after a timeout: the fabric still owes one rvalid for the abandoned
  // transaction, and it must be swallowed before a new request is issued.
  logic             drop_pending;
  logic             reg_error_q;

  assign reg_error_o = reg_error_q;
`else
  assign reg_error_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      reg_ready_o  <= 1'b0;
      reg_rdata_o  <= '0;
      obi_req_o    <= 1'b0;
      obi_addr_o   <= '0;
      obi_we_o     <= 1'b0;
      obi_be_o     <= '0;
      obi_wdata_o  <= '0;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
      cnt          <= '0;
      drop_pending <= 1'b0;
      reg_error_q  <= 1'b0;
`endif
    end else begin
      reg_ready_o <= 1'b0;
      case (state)
        IDLE: begin
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
          // A late response for a timed-out transaction is discarded here.
          if (obi_rvalid_i) drop_pending <= 1'b0;
`endif
          if (reg_valid_i) begin
            if (reg_write_i && reg_wstrb_i == 4'h0) begin
              // Nothing to write: complete locally without OBI traffic.
              reg_rdata_o <= '0;
              reg_ready_o <= 1'b1;
              state       <= DONE;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
              reg_error_q <= 1'b0;
`endif
            end else begin
              obi_addr_o  <= {reg_addr_i[31:2], 2'b00};
              obi_we_o    <= reg_write_i;
              obi_be_o    <= reg_write_i ? reg_wstrb_i : 4'hF;
              obi_wdata_o <= reg_wdata_i;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
              if (drop_pending && !obi_rvalid_i) begin
                state <= DRAIN;
              end else begin
                obi_req_o <= 1'b1;
                state     <= REQ;
              end
`else
              obi_req_o <= 1'b1;
              state     <= REQ;
`endif
            end
          end
        end
        REQ: begin
          // Address phase held until granted; an rvalid here is ignored.
          if (obi_gnt_i) begin
            obi_req_o <= 1'b0;
            state     <= RESP;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
            cnt       <= '0;
`endif
          end
        end
        RESP: begin
          if (obi_rvalid_i) begin
            reg_rdata_o <= obi_we_o ? 32'h0 : obi_rdata_i;
            reg_ready_o <= 1'b1;
            state       <= DONE;
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
            reg_error_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            reg_rdata_o  <= ERR_RDATA;
            reg_error_q  <= 1'b1;
            reg_ready_o  <= 1'b1;
            drop_pending <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          // reg_valid_i here still belongs to the finishing transfer.
          state <= IDLE;
        end
`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
        DRAIN: begin
          if (obi_rvalid_i) begin
            drop_pending <= 1'b0;
            obi_req_o    <= 1'b1;
            state        <= REQ;
          end
        end
`endif
        default: begin
          obi_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_to_obi_bridge.sv
module tb_reg_to_obi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        reg_valid_i, reg_write_i;
  logic [31:0] reg_addr_i, reg_wdata_i;
  logic [3:0]  reg_wstrb_i;
  logic        reg_ready_o, reg_error_o;
  logic [31:0] reg_rdata_o;
  logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
  logic [3:0]  obi_be_o;

  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  always #5 clk_i = ~clk_i;

  reg_to_obi_bridge #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERR_RDATA)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .reg_valid_i(reg_valid_i), .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i), .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } obi_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  obi_t obi_q[$];
  rsp_t reg_q[$];

  int n_checks   = 0;
  int n_err      = 0;
  int pulses     = 0;
  int exp_pulses = 0;
  int gnt_force  = -1;   // -1: random grant delay
  int rv_force   = -1;   // -1: random response delay, -2: withhold response
  bit rst_test   = 1'b0;
  bit late_fire  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_addr_phase(input obi_t c);
    check("obi_req", {31'b0, obi_req_o}, 32'd1);
    check("obi_addr", obi_addr_o, c.addr);
    check("obi_we", {31'b0, obi_we_o}, {31'b0, c.we});
    check("obi_be", {28'b0, obi_be_o}, {28'b0, c.be});
    check("obi_wdata", obi_wdata_o, c.wdata);
  endtask

  // Reference model: what the bridge should do for one reg-bus transfer.
  task automatic push_expect(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [31:0] rdata, input bit to_exp);
    obi_t o;
    rsp_t r;
    if (we && strb == 4'h0) begin
      r.rdata = 32'h0;
      r.err   = 1'b0;
    end else begin
      o.addr  = addr & 32'hFFFF_FFFC;
      o.we    = we;
      o.be    = we ? strb : 4'hF;
      o.wdata = wdata;
      o.rdata = rdata;
      obi_q.push_back(o);
      r.rdata = to_exp ? ERR_RDATA : (we ? 32'h0 : rdata);
      r.err   = to_exp;
    end
    reg_q.push_back(r);
    exp_pulses++;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (1) begin
      @(negedge clk_i);
      if (reg_ready_o === 1'b1) break;
      lat++;
      if (lat > 300) begin
        n_checks++;
        n_err++;
        $display("FAIL ready_wait: got no reg_ready_o expected a pulse within 300 cycles");
        break;
      end
    end
  endtask

  // Called just after a rising edge; leaves reg_valid_i asserted on return.
  task automatic do_xfer(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] rdata,
                         input int exp_lat, input bit to_exp);
    int lat;
    push_expect(we, addr, wdata, strb, rdata, to_exp);
    reg_valid_i = 1'b1;
    reg_write_i = we;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = strb;
    wait_ready(lat);
    if (exp_lat >= 0) check("latency", lat, exp_lat);
    @(posedge clk_i);
    #1;
  endtask

  // Reg-bus response monitor / scoreboard.
  initial begin
    bit   prev_ready;
    rsp_t r;
    prev_ready = 1'b0;
    forever begin
      @(negedge clk_i);
      if (reg_ready_o === 1'b1) begin
        pulses++;
        check("ready_single_cycle", {31'b0, prev_ready}, 32'd0);
        if (reg_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_ready: got a pulse expected none");
        end else begin
          r = reg_q.pop_front();
          check("reg_rdata", reg_rdata_o, r.rdata);
          check("reg_error", {31'b0, reg_error_o}, {31'b0, r.err});
        end
      end
      prev_ready = (reg_ready_o === 1'b1);
    end
  end

  // OBI target model: checks the address phase and answers with queued data.
  initial begin
    obi_t cur;
    int   d, rv;
    bit   aborted;
    obi_gnt_i    = 1'b0;
    obi_rvalid_i = 1'b0;
    obi_rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      obi_gnt_i    = 1'b0;
      obi_rvalid_i = 1'b0;
      if (late_fire) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = $urandom;
        late_fire    = 1'b0;
      end else if (rst_ni && obi_req_o) begin
        if (obi_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_obi_req: got addr %h expected no request", obi_addr_o);
          cur.addr = obi_addr_o; cur.we = obi_we_o; cur.be = obi_be_o;
          cur.wdata = obi_wdata_o; cur.rdata = 32'h0;
        end else begin
          cur = obi_q.pop_front();
        end
        chk_addr_phase(cur);
        d = (gnt_force >= 0) ? gnt_force : int'($urandom_range(0, 3));
        aborted = 1'b0;
        for (int i = 0; i < d && !aborted; i++) begin
          @(negedge clk_i);
          if (!rst_ni || !obi_req_o) begin
            aborted = 1'b1;
            if (!rst_test) begin
              n_checks++;
              n_err++;
              $display("FAIL obi_req_withdrawn: got req 0 expected 1");
            end
          end else begin
            chk_addr_phase(cur);
          end
        end
        if (!aborted) begin
          obi_gnt_i = 1'b1;
          if (gnt_force < 0 && $urandom_range(0, 2) == 0) begin
            obi_rvalid_i = 1'b1;        // stray rvalid in the grant cycle
            obi_rdata_i  = $urandom;
          end
          @(negedge clk_i);
          obi_gnt_i    = 1'b0;
          obi_rvalid_i = 1'b0;
          if (rv_force != -2) begin
            rv = (rv_force >= 0) ? rv_force : int'($urandom_range(0, 3));
            repeat (rv) @(negedge clk_i);
            obi_rvalid_i = 1'b1;
            obi_rdata_i  = cur.rdata;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [3:0]  s;
    logic [31:0] a, w, rd;
    int          lat;

    rst_ni      = 1'b1;
    reg_valid_i = 1'b0;
    reg_write_i = 1'b0;
    reg_addr_i  = '0;
    reg_wdata_i = '0;
    reg_wstrb_i = '0;
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req", {31'b0, obi_req_o}, 32'd0);
    check("rst_ready", {31'b0, reg_ready_o}, 32'd0);
    check("rst_rdata", reg_rdata_o, 32'd0);
    check("rst_error", {31'b0, reg_error_o}, 32'd0);
    check("rst_addr", obi_addr_o, 32'd0);
    check("rst_we", {31'b0, obi_we_o}, 32'd0);
    check("rst_be", {28'b0, obi_be_o}, 32'd0);
    check("rst_wdata", obi_wdata_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Unaligned read, immediate grant, response next cycle.
    gnt_force = 0; rv_force = 0;
    do_xfer(1'b0, 32'h2000_0406, 32'h0, 4'h0, 32'hCAFE_F00D, 3, 1'b0);
    reg_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Write with grant held off 5 cycles.
    gnt_force = 5;
    do_xfer(1'b1, 32'h0000_0010, 32'h1234_5678, 4'h6, 32'hFFFF_FFFF, 8, 1'b0);
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Zero-strobe write completes locally.
    gnt_force = 0;
    do_xfer(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 4'h0, 32'h0, 1, 1'b0);
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Two back-to-back reads with valid held continuously.
    gnt_force = -1; rv_force = -1;
    do_xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h1111_2222, -1, 1'b0);
    do_xfer(1'b0, 32'h0000_1004, 32'h0, 4'h0, 32'h3333_4444, -1, 1'b0);
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      we = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      if (k % 7 == 3) s = 4'h0;
      a  = $urandom;
      w  = $urandom;
      rd = $urandom;
      do_xfer(we, a, w, s, rd, -1, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        reg_valid_i = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk_i);
        #1;
      end
    end
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset while waiting for grant.
    rst_test = 1'b1; gnt_force = 20; rv_force = 0;
    begin
      obi_t o;
      o.addr = 32'h0000_0200; o.we = 1'b0; o.be = 4'hF; o.wdata = 32'h0; o.rdata = 32'h0;
      obi_q.push_back(o);
    end
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = 32'h0000_0200;
    reg_wdata_i = 32'h0; reg_wstrb_i = 4'h0;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_req", {31'b0, obi_req_o}, 32'd0);
    check("async_rst_ready", {31'b0, reg_ready_o}, 32'd0);
    check("async_rst_addr", obi_addr_o, 32'd0);
    reg_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    rst_test = 1'b0; gnt_force = 0; rv_force = 0;
    @(posedge clk_i);
    #1;
    do_xfer(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h5A5A_A5A5, 3, 1'b0);
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;

`ifdef REG_TO_OBI_BRIDGE_TIMEOUT_EN
    // Response withheld: error after 8 RESP cycles, then a drained restart.
    rv_force = -2;
    do_xfer(1'b0, 32'h0000_0500, 32'h0, 4'h0, 32'h0, 10, 1'b1);
    rv_force = 0;
    push_expect(1'b0, 32'h0000_0600, 32'h0, 4'h0, 32'h7777_8888, 1'b0);
    reg_valid_i = 1'b1; reg_write_i = 1'b0; reg_addr_i = 32'h0000_0600;
    reg_wdata_i = 32'h0; reg_wstrb_i = 4'h0;
    repeat (4) begin
      @(negedge clk_i);
      check("drain_no_req", {31'b0, obi_req_o}, 32'd0);
    end
    late_fire = 1'b1;
    wait_ready(lat);
    @(posedge clk_i);
    #1;
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
`endif

    repeat (5) @(posedge clk_i);
    #1;
    check("ready_pulse_count", pulses, exp_pulses);
    check("obi_queue_empty", obi_q.size(), 0);
    check("reg_queue_empty", reg_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
